// File: rtl/mouse_decoder.sv
// Serial mouse packet decoder: 11-bit odd-parity frames, 3-byte packets.
// Keeps a clamped X position and the left button state.
module mouse_decoder #(
  parameter logic [15:0] X_MAX   = 16'd639,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        serial_valid,
  input  logic        serial_data,
  output logic [15:0] mouse_x,
  output logic        mouse_pressed_,
  output logic        packet_strobe,
  output logic        frame_error
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [1:0]  byte_idx;
  logic [7:0]  status_q;
  logic [7:0]  xbyte_q;
  logic [15:0] tcnt;
  logic [15:0] tcnt_nx;
  logic        active;
  logic        timeout;
  logic        stop_seen;
  logic        frame_bad;
  logic        commit;
  logic [17:0] delta;
  logic [17:0] sum;
  logic [15:0] x_new;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = IDLE;
    end else if (serial_valid) begin
      unique case (state)
        IDLE:    if (!serial_data) state_nx = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // par_q accumulates data ^ parity; odd parity means it ends at 1
  always_comb begin
    active    = (state != IDLE) || (byte_idx != 2'd0);
    tcnt_nx   = tcnt + 16'd1;
    timeout   = !serial_valid && active && (tcnt_nx >= TIMEOUT);
    stop_seen = serial_valid && (state == STOP);
    frame_bad = stop_seen && (!par_q || !serial_data ||
                ((byte_idx == 2'd0) && !shift_q[3]));
    commit    = stop_seen && !frame_bad && (byte_idx == 2'd2);
  end

  always_comb begin
    delta = {{10{status_q[4]}}, xbyte_q};
    sum   = {2'b00, mouse_x} + delta;
    x_new = sum[15:0];
    unique case (1'b1)
      sum[17]:
        x_new = '0;
      !sum[17] && (sum[16:0] > {1'b0, X_MAX}):
        x_new = X_MAX;
      default:
        x_new = sum[15:0];
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      byte_idx <= '0;
      status_q <= '0;
      xbyte_q  <= '0;
      tcnt     <= '0;
    end else begin
      if (serial_valid || timeout) tcnt <= '0;
      else if (active)             tcnt <= tcnt_nx;
      if (timeout) begin
        byte_idx <= '0;
      end else if (serial_valid) begin
        unique case (state)
          IDLE: begin
            bit_cnt <= '0;
            par_q   <= 1'b0;
          end
          DATA: begin
            shift_q <= {serial_data, shift_q[7:1]};
            par_q   <= par_q ^ serial_data;
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_q <= par_q ^ serial_data;
          STOP: begin
            if (frame_bad) begin
              byte_idx <= '0;
            end else begin
              case (byte_idx)
                2'd0: begin
                  status_q <= shift_q;
                  byte_idx <= 2'd1;
                end
                2'd1: begin
                  xbyte_q  <= shift_q;
                  byte_idx <= 2'd2;
                end
                default: byte_idx <= '0;
              endcase
            end
          end
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

  // overflow packets still report the button
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      mouse_x        <= '0;
      mouse_pressed_ <= 1'b1;
      packet_strobe  <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      packet_strobe <= commit;
      frame_error   <= frame_bad || timeout;
      if (commit) begin
        mouse_pressed_ <= ~status_q[0];
        if (!status_q[6]) mouse_x <= x_new;
      end
    end
  end

endmodule

// File: tb/tb_mouse_decoder.sv
// Self-checking bench for mouse_decoder.
// Random line gaps and packets checked against an integer position model.
module tb_mouse_decoder;

  logic        clock = 1'b0;
  logic        reset_;
  logic        serial_valid;
  logic        serial_data;
  logic [15:0] mouse_x;
  logic        mouse_pressed_;
  logic        packet_strobe;
  logic        frame_error;

  int   total = 0;
  int   bad = 0;
  int   stb_cnt = 0;
  int   err_cnt = 0;
  int   exp_x = 0;
  logic exp_p = 1'b1;
  bit   gap_en = 1'b1;

  mouse_decoder dut (
    .clock          (clock),
    .reset_         (reset_),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .mouse_x        (mouse_x),
    .mouse_pressed_ (mouse_pressed_),
    .packet_strobe  (packet_strobe),
    .frame_error    (frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (packet_strobe === 1'b1) stb_cnt++;
    if (frame_error === 1'b1) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        serial_valid = 1'b0;
        serial_data  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clock);
    serial_valid = 1'b1;
    serial_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      serial_valid = 1'b0;
      serial_data  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit bad_par,
                            input bit bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((~^b) ^ bad_par);
    drive_bit(!bad_stop);
  endtask

  // Reference: signed delta, add, clamp to [0, 639]
  task automatic model(input logic [7:0] st, input logic [7:0] dx);
    int d;
    int n;
    if (!st[6]) begin
      d = st[4] ? int'(dx) - 256 : int'(dx);
      n = exp_x + d;
      if (n < 0) n = 0;
      else if (n > 639) n = 639;
      exp_x = n;
    end
    exp_p = ~st[0];
  endtask

  task automatic send_packet(input logic [7:0] st,
                             input logic [7:0] dx,
                             input logic [7:0] dy);
    send_frame(st, 1'b0, 1'b0);
    send_frame(dx, 1'b0, 1'b0);
    send_frame(dy, 1'b0, 1'b0);
    model(st, dx);
    @(negedge clock);
    serial_valid = 1'b0;
    total++;
    if (packet_strobe !== 1'b1) begin
      bad++;
      $display("FAIL pkt_strobe st=%h dx=%h got=%b want=1",
               st, dx, packet_strobe);
    end
    total++;
    if (mouse_x !== exp_x[15:0]) begin
      bad++;
      $display("FAIL pkt_x st=%h dx=%h got=%0d want=%0d",
               st, dx, mouse_x, exp_x);
    end
    total++;
    if (mouse_pressed_ !== exp_p) begin
      bad++;
      $display("FAIL pkt_btn st=%h got=%b want=%b",
               st, mouse_pressed_, exp_p);
    end
    @(negedge clock);
    total++;
    if (packet_strobe !== 1'b0) begin
      bad++;
      $display("FAIL pkt_pulse got=%b want=0", packet_strobe);
    end
  endtask

  task automatic test_reset();
    serial_valid = 1'b0;
    serial_data  = 1'b0;
    reset_ = 1'b1;
    #1 reset_ = 1'b0;
    #1;
    total++;
    if (mouse_x !== 16'd0) begin
      bad++;
      $display("FAIL rst_x got=%0d want=0", mouse_x);
    end
    total++;
    if (mouse_pressed_ !== 1'b1) begin
      bad++;
      $display("FAIL rst_btn got=%b want=1", mouse_pressed_);
    end
    total++;
    if (packet_strobe !== 1'b0) begin
      bad++;
      $display("FAIL rst_strobe got=%b want=0", packet_strobe);
    end
    total++;
    if (frame_error !== 1'b0) begin
      bad++;
      $display("FAIL rst_err got=%b want=0", frame_error);
    end
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int s0;
    s0 = stb_cnt;
    send_packet(8'h09, 8'h05, 8'h00);
    idle(3);
    total++;
    if (stb_cnt - s0 != 1) begin
      bad++;
      $display("FAIL basic_strobes got=%0d want=1", stb_cnt - s0);
    end
  endtask

  task automatic test_low_clamp();
    send_packet(8'h18, 8'hFE, 8'h00);
    send_packet(8'h18, 8'hF6, 8'h00);
  endtask

  task automatic test_high_clamp();
    repeat (4) send_packet(8'h08, 8'h7F, 8'h00);
    send_packet(8'h08, 8'h7A, 8'h00);
    send_packet(8'h08, 8'h08, 8'h00);
    send_packet(8'h08, 8'h08, 8'h00);
    send_packet(8'h48, 8'h08, 8'h00);
    send_packet(8'h59, 8'h9C, 8'h00);
  endtask

  task automatic test_frame_errors();
    int s0;
    int e0;
    s0 = stb_cnt;
    e0 = err_cnt;
    send_frame(8'h09, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h04, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1);
    idle(5);
    total++;
    if (err_cnt - e0 != 3) begin
      bad++;
      $display("FAIL ferr_count got=%0d want=3", err_cnt - e0);
    end
    total++;
    if (stb_cnt - s0 != 0) begin
      bad++;
      $display("FAIL ferr_strobe got=%0d want=0", stb_cnt - s0);
    end
    total++;
    if (mouse_x !== exp_x[15:0]) begin
      bad++;
      $display("FAIL ferr_hold got=%0d want=%0d", mouse_x, exp_x);
    end
    send_packet(8'h08, 8'hF0, 8'h00);
  endtask

  task automatic test_timeout();
    int s0;
    int e0;
    s0 = stb_cnt;
    e0 = err_cnt;
    send_frame(8'h09, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    idle(990);
    total++;
    if (err_cnt - e0 != 0) begin
      bad++;
      $display("FAIL tmo_early got=%0d want=0", err_cnt - e0);
    end
    idle(110);
    total++;
    if (err_cnt - e0 != 1) begin
      bad++;
      $display("FAIL tmo_count got=%0d want=1", err_cnt - e0);
    end
    total++;
    if (stb_cnt - s0 != 0 || mouse_x !== exp_x[15:0]) begin
      bad++;
      $display("FAIL tmo_hold strobes=%0d x=%0d want 0,%0d",
               stb_cnt - s0, mouse_x, exp_x);
    end
    send_packet(8'h09, 8'h11, 8'h00);
  endtask

  task automatic test_reset_mid();
    send_frame(8'h09, 1'b0, 1'b0);
    send_frame(8'h20, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    @(negedge clock);
    serial_valid = 1'b0;
    reset_ = 1'b0;
    #1;
    total++;
    if (mouse_x !== 16'd0 || mouse_pressed_ !== 1'b1) begin
      bad++;
      $display("FAIL midrst_out x=%0d btn=%b want 0,1",
               mouse_x, mouse_pressed_);
    end
    total++;
    if (packet_strobe !== 1'b0 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL midrst_pulse stb=%b err=%b want 0,0",
               packet_strobe, frame_error);
    end
    @(negedge clock);
    reset_ = 1'b1;
    exp_x = 0;
    exp_p = 1'b1;
    idle(2);
    send_packet(8'h09, 8'h07, 8'h00);
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = stb_cnt;
    gap_en = 1'b0;
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h10, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h09, 1'b0, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    gap_en = 1'b1;
    model(8'h08, 8'h10);
    model(8'h09, 8'h05);
    idle(3);
    total++;
    if (stb_cnt - s0 != 2) begin
      bad++;
      $display("FAIL b2b_strobes got=%0d want=2", stb_cnt - s0);
    end
    total++;
    if (mouse_x !== exp_x[15:0] || mouse_pressed_ !== exp_p) begin
      bad++;
      $display("FAIL b2b_out x=%0d btn=%b want %0d,%b",
               mouse_x, mouse_pressed_, exp_x, exp_p);
    end
  endtask

  task automatic test_random();
    logic [7:0] st;
    logic [7:0] dx;
    int e0;
    e0 = err_cnt;
    for (int n = 0; n < 40; n++) begin
      st = 8'($urandom);
      st[3] = 1'b1;
      if ($urandom_range(0, 7) != 0) st[6] = 1'b0;
      dx = 8'($urandom);
      send_packet(st, dx, 8'($urandom));
      idle($urandom_range(0, 3));
    end
    total++;
    if (err_cnt != e0) begin
      bad++;
      $display("FAIL rand_err got=%0d want=0", err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_low_clamp();
    test_high_clamp();
    test_frame_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
